// File: rtl/mem_pkg.sv
// Shared types and lane/size helpers for byte_lane_memory and its byte lanes.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WR2,
        RD1,
        RD2,
        FMT
    } mem_state_e;

    function automatic logic [2:0] size_to_bytes(input mem_size_e size);
        case (size)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            MEM_WORD: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

    // Returns {lanes of word w, lanes of word w+1}; a reserved size touches no lane.
    function automatic logic [7:0] lane_mask(input logic [1:0] lane, input mem_size_e size);
        logic [7:0] span;
        span = 8'((9'd1 << size_to_bytes(size)) - 9'd1) << lane;
        return {span[3:0], span[7:4]};
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// One 8-bit byte lane: single-port array with write enable and registered read.
module mem_byte_lane #(
    parameter int WORDS = 64
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [$clog2(WORDS)-1:0] i_addr,
    input  logic [7:0]               i_wdata,
    output logic [7:0]               o_rdata
);

    // NOTE: the array has no reset so it maps onto block RAM; zeroing is done by the CLEAR sweep.
    logic [7:0] r_mem [WORDS];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_lane_memory.sv
// Little-endian byte-addressable RAM of four byte lanes with valid/ready handshake.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of splitting them.
module byte_lane_memory
    import mem_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = AW - 2;

    mem_state_e      r_state;
    logic [WW-1:0]   r_clr_cnt;
    logic            r_resp_valid;
    logic [31:0]     r_resp_rdata;
    logic            r_resp_err;
    logic            r_sticky;

    logic [WW-1:0]   r_word;
    logic [1:0]      r_lane;
    mem_size_e       r_size;
    logic            r_signed;
    logic [3:0]      r_mask1;
    logic [31:0]     r_wrot;
    logic            r_split;
    logic            r_err;
    logic [31:0]     r_word0;
    logic [31:0]     r_word1;

    logic [AW-1:0]   w_addr;
    logic [1:0]      w_lane;
    logic [WW-1:0]   w_word;
    mem_size_e       w_size;
    logic [7:0]      w_masks;
    logic [3:0]      w_mask0;
    logic [3:0]      w_mask1;
    logic            w_misaligned;
    logic            w_bad_load;
    logic            w_split;
    logic            w_accept;
    logic [63:0]     w_wdup;
    logic [31:0]     w_wrot;
    logic [63:0]     w_rdup;
    logic [31:0]     w_raw;
    logic [31:0]     w_fmt;
    logic            w_unused_addr;

    logic            w_lane_en;
    logic [3:0]      w_lane_we;
    logic [WW-1:0]   w_lane_addr;
    logic [31:0]     w_lane_wdata;
    logic [31:0]     w_lane_rdata;

    assign w_addr        = req_addr[AW-1:0];
    assign w_lane        = w_addr[1:0];
    assign w_word        = w_addr[AW-1:2];
    assign w_size        = mem_size_e'(req_size);
    assign w_masks       = lane_mask(w_lane, w_size);
    assign w_mask0       = w_masks[7:4];
    assign w_mask1       = w_masks[3:0];
    assign w_unused_addr = &{1'b0, req_addr[ADDR_W-1:AW]};

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = ((w_size == MEM_HALF) && w_lane[0]) ||
                          ((w_size == MEM_WORD) && (w_lane != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_bad_load = (w_size == MEM_RSVD) || w_misaligned;
    assign w_split    = (|w_mask1) && !w_misaligned;

    assign req_ready  = !rst && (r_state == IDLE) && (!r_resp_valid || resp_ready);
    assign w_accept   = req_valid && req_ready;

    // Rotating the store data by the lane offset puts byte k on lane (a+k)%4 for both words.
    assign w_wdup = {req_wdata, req_wdata} << {w_lane, 3'b000};
    assign w_wrot = w_wdup[63:32];

    assign w_rdup = {r_word1, r_word0} >> {r_lane, 3'b000};
    assign w_raw  = w_rdup[31:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_fmt = w_raw;
        case (r_size)
            MEM_BYTE: w_fmt = {{24{r_signed & w_raw[7]}}, w_raw[7:0]};
            MEM_HALF: w_fmt = {{16{r_signed & w_raw[15]}}, w_raw[15:0]};
            default:  w_fmt = w_raw;
        endcase
    end

    always_comb begin
        w_lane_en    = 1'b0;
        w_lane_we    = 4'h0;
        w_lane_addr  = w_word;
        w_lane_wdata = w_wrot;
        case (r_state)
            CLEAR: begin
                w_lane_en    = 1'b1;
                w_lane_we    = 4'hF;
                w_lane_addr  = r_clr_cnt;
                w_lane_wdata = 32'h0;
            end
            IDLE: begin
                if (w_accept) begin
                    if (req_write) begin
                        w_lane_en = !w_misaligned;
                        w_lane_we = w_misaligned ? 4'h0 : w_mask0;
                    end else begin
                        w_lane_en = !w_bad_load;
                    end
                end
            end
            WR2: begin
                w_lane_en    = 1'b1;
                w_lane_we    = r_mask1;
                w_lane_addr  = r_word + WW'(1);
                w_lane_wdata = r_wrot;
            end
            RD1: begin
                w_lane_en   = r_split;
                w_lane_addr = r_word + WW'(1);
            end
            default: ;
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        mem_byte_lane #(.WORDS(DEPTH / 4)) u_lane (
            .clk     (clk),
            .i_en    (w_lane_en),
            .i_we    (w_lane_we[l]),
            .i_addr  (w_lane_addr),
            .i_wdata (w_lane_wdata[8*l +: 8]),
            .o_rdata (w_lane_rdata[8*l +: 8])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            r_clr_cnt    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            r_sticky     <= 1'b0;
        end else begin
            if (r_resp_valid && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
            case (r_state)
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + WW'(1);
                    if (r_clr_cnt == WW'(DEPTH / 4 - 1)) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        if (!req_write) begin
                            r_state <= RD1;
                        end else if (w_misaligned) begin
                            r_sticky <= 1'b1;
                        end else if (w_split) begin
                            r_state <= WR2;
                        end
                    end
                end
                WR2: r_state <= IDLE;
                RD1: r_state <= r_split ? RD2 : FMT;
                RD2: r_state <= FMT;
                FMT: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_err ? 32'h0 : w_fmt;
                    r_resp_err   <= r_err || r_sticky;
                    r_sticky     <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Access context needs no reset: it is always written before the state that reads it.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_accept) begin
            r_word   <= w_word;
            r_lane   <= w_lane;
            r_size   <= w_size;
            r_signed <= req_signed;
            r_mask1  <= w_mask1;
            r_wrot   <= w_wrot;
            r_split  <= w_split && !(w_bad_load && !req_write);
            r_err    <= w_bad_load;
        end
        if (r_state == RD1) begin
            r_word0 <= w_lane_rdata;
        end
        if (r_state == RD2) begin
            r_word1 <= w_lane_rdata;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_byte_lane_memory.sv
// Directed table-driven bench for byte_lane_memory (DEPTH=256, CLEAR_ON_RESET=1).
module tb_byte_lane_memory;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    byte_lane_memory #(
        .DEPTH          (256),
        .ADDR_W         (32),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge, i.e. in cycle t+1.
    task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] data, output logic err, output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        data       = resp_rdata;
        err        = resp_err;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            n++;
            step();
        end
        check(name, n, 32'd64);
    endtask

    function automatic vec_t ld(string nm, logic [1:0] sz, logic sg, logic [31:0] a,
                                logic [31:0] d, logic e, int lat);
        return '{nm, 1'b0, sz, sg, a, 32'h0, d, e, lat};
    endfunction

    function automatic vec_t st(string nm, logic [1:0] sz, logic [31:0] a,
                                logic [31:0] wd, int busy);
        return '{nm, 1'b1, sz, 1'b0, a, wd, 32'h0, 1'b0, busy};
    endfunction

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        logic [31:0] d;
        logic        e;
        int          lat;
        int          n;

        forever begin
            #200000;
            $display("FAIL watchdog: got timeout expected finish");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        logic [31:0] d;
        logic        e;
        int          lat;
        int          n;
        logic [31:0] hold_exp;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        count_clear("clear_cycles");

        vecs.push_back(ld("ld_w_fc",     2'd2, 1'b0, 32'hFC, 32'h0, 1'b0, 3));
        vecs.push_back(st("st_w_10",     2'd2, 32'h10, 32'hDEADBEEF, 0));
        vecs.push_back(ld("ld_bs_13",    2'd0, 1'b1, 32'h13, 32'hFFFFFFDE, 1'b0, 3));
        vecs.push_back(ld("ld_bu_13",    2'd0, 1'b0, 32'h13, 32'h000000DE, 1'b0, 3));
        vecs.push_back(st("st_w_0e",     2'd2, 32'h0E, 32'h11223344, TRAP ? 0 : 1));
        vecs.push_back(ld("ld_w_0e",     2'd2, 1'b0, 32'h0E, TRAP ? 32'h0 : 32'h11223344, TRAP, TRAP ? 3 : 4));
        vecs.push_back(ld("ld_b_11",     2'd0, 1'b0, 32'h11, TRAP ? 32'hBE : 32'h11, 1'b0, 3));
        vecs.push_back(st("st_h_ff",     2'd1, 32'hFF, 32'h0000A55A, TRAP ? 0 : 1));
        vecs.push_back(ld("ld_b_ff",     2'd0, 1'b0, 32'hFF, TRAP ? 32'h0 : 32'h5A, TRAP, 3));
        vecs.push_back(ld("ld_b_00",     2'd0, 1'b0, 32'h100, TRAP ? 32'h0 : 32'hA5, 1'b0, 3));
        vecs.push_back(ld("ld_hs_ff",    2'd1, 1'b1, 32'hFF, TRAP ? 32'h0 : 32'hFFFFA55A, TRAP, TRAP ? 3 : 4));
        vecs.push_back(ld("ld_hu_ff",    2'd1, 1'b0, 32'hFF, TRAP ? 32'h0 : 32'h0000A55A, TRAP, TRAP ? 3 : 4));
        vecs.push_back(ld("ld_w_10",     2'd2, 1'b0, 32'h10, TRAP ? 32'hDEADBEEF : 32'hDEAD1122, 1'b0, 3));
        vecs.push_back(ld("ld_hs_12",    2'd1, 1'b1, 32'h12, 32'hFFFFDEAD, 1'b0, 3));
        vecs.push_back(ld("ld_rsvd",     2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 3));
        vecs.push_back(st("st_rsvd",     2'd3, 32'h10, 32'hFFFFFFFF, 0));
        vecs.push_back(ld("ld_w_10b",    2'd2, 1'b0, 32'h10, TRAP ? 32'hDEADBEEF : 32'hDEAD1122, 1'b0, 3));
        vecs.push_back(st("st_w_02",     2'd2, 32'h02, 32'hCAFEF00D, TRAP ? 0 : 1));
        vecs.push_back(ld("ld_w_02",     2'd2, 1'b0, 32'h02, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP, TRAP ? 3 : 4));
        vecs.push_back(ld("ld_hu_04",    2'd1, 1'b0, 32'h04, TRAP ? 32'h0 : 32'h0000CAFE, 1'b0, 3));
        vecs.push_back(st("st_h_21",     2'd1, 32'h21, 32'h00001234, 0));
        vecs.push_back(ld("ld_b_22",     2'd0, 1'b0, 32'h22, TRAP ? 32'h0 : 32'h12, TRAP, 3));
        vecs.push_back(ld("ld_b_22b",    2'd0, 1'b0, 32'h22, TRAP ? 32'h0 : 32'h12, 1'b0, 3));

        foreach (vecs[i]) begin
            v = vecs[i];
            send(v.wr, v.size, v.sgn, v.addr, v.wdata);
            if (v.wr) begin
                check({v.name, "_ready"}, 32'(req_ready), 32'(v.exp_lat == 0));
                n = 0;
                while (!req_ready && n < 10) begin
                    step();
                    n++;
                end
            end else begin
                get_resp(d, e, lat);
                check({v.name, "_data"}, d, v.exp_data);
                check({v.name, "_err"}, 32'(e), 32'(v.exp_err));
                check({v.name, "_lat"}, lat, v.exp_lat);
            end
        end

        // Response held under back-pressure, then released with req_ready rising in the same cycle.
        hold_exp = TRAP ? 32'hDEADBEEF : 32'hDEAD1122;
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        n = 0;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, hold_exp);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("release_req_ready", 32'(req_ready), 32'd1);
        step();
        resp_ready = 1'b0;
        check("release_valid", 32'(resp_valid), 32'd0);

        // Reset during RD1 must drop the load and restart the sweep.
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rd1_rst_valid", 32'(resp_valid), 32'd0);
            check("rd1_rst_ready", 32'(req_ready), 32'd0);
        end
        rst = 1'b0;
        count_clear("reclear_cycles");
        check("reclear_no_resp", 32'(resp_valid), 32'd0);
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        get_resp(d, e, lat);
        check("reclear_ld_data", d, 32'h0);
        check("reclear_ld_lat", lat, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/byte_lane_memory.md
Name: byte_lane_memory

Overview:
- Parametrised successor to the single-cycle byte-addressed data memory.
- Little-endian, byte-addressable RAM built as four 8-bit byte lanes of DEPTH/4 entries each, so each lane infers one BRAM.
- Adds a valid/ready request/response handshake, sign-extending loads, and misaligned accesses that cross a word boundary, split into two beats.
- Adds a zero-fill sweep after reset.
- Sits between the core's load/store unit and on-chip storage.

Parameters:
- DEPTH, 256, size in bytes; must be a power of two and at least 8.
- ADDR_W, 32, request address width; bits above log2(DEPTH) are ignored, so addresses wrap modulo DEPTH.
- CLEAR_ON_RESET, 1, 1 = zero-fill all bytes after reset; 0 = go straight to IDLE with contents undefined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend a byte/half load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  load result available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load data, zero- or sign-extended.
- resp_err  out  1  error flag, qualified by resp_valid.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0. State becomes CLEAR (or IDLE when CLEAR_ON_RESET=0).
- Reset asserted in any cycle aborts any in-flight access, drops a pending response, and restarts CLEAR.
- Addressing: a = req_addr mod DEPTH; word index w = a>>2; lane = a[1:0]. Byte k of the access goes to address (a+k) mod DEPTH, so the last word wraps to address 0.
- Split: an access whose bytes span words w and w+1 (mod DEPTH/4).
- States:
  - CLEAR: counter runs 0..DEPTH/4-1, writing 0 to all four lanes at one word per cycle; req_ready=0. Enters IDLE after the last word, i.e. DEPTH/4 cycles after reset deasserts.
  - IDLE: req_ready = !resp_valid || resp_ready.
  - WR2: second beat of a split store; req_ready=0.
  - RD1: first read word captured; req_ready=0.
  - RD2: second read word captured (split loads only); req_ready=0.
  - FMT: assemble lanes and extend, load response register; req_ready=0.
- Store accepted in cycle t: lanes of word w written at the end of t. A non-split store stays in IDLE, so a new request can be accepted in t+1. A split store goes to WR2 and writes the remaining lanes of w+1 at the end of t+1. Stores never produce a response.
- Load accepted in cycle t:
  - Non-split: RD1 at t+1, FMT at t+2, resp_valid=1 from t+3.
  - Split: RD1, RD2, FMT, resp_valid=1 from t+4.
- resp_valid, resp_rdata and resp_err are held stable until resp_valid && resp_ready. resp_valid then drops unless a new response loads in the same edge, which cannot happen with one outstanding access.
- At most one load is outstanding. req_ready may rise in the same cycle resp_ready completes the handshake.
- Load formatting:
  - Byte: zero-extend, or sign-extend from bit 7 when req_signed.
  - Half: zero-extend, or sign-extend from bit 15 when req_signed.
  - Word: req_signed ignored.
  - req_signed is captured at acceptance.
- A load in the cycle after a store to the same address returns the new data; no bypass is needed because the write completes before the read beat.
- req_size=11:
  - Load: no array access; a response with resp_err=1 and resp_rdata=0 at the normal non-split latency.
  - Store: dropped.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined: a half access at an odd address, or a word access with a[1:0]!=0, is rejected and no array write occurs.
  - Misaligned load: response with resp_err=1 and resp_rdata=0 at the non-split load latency.
  - Misaligned store: dropped silently. A sticky bit is exposed only through the error of the next load response, with resp_err=1 and correct data; the sticky bit clears on that response.
- Macro not defined: misaligned accesses are legal and handled as in-word or split accesses as above. resp_err is raised only for size 11.

Decomposition:
- Package mem_pkg:
  - mem_size_e (MEM_BYTE=2'b00, MEM_HALF, MEM_WORD, MEM_RSVD).
  - mem_state_e (CLEAR, IDLE, WR2, RD1, RD2, FMT).
  - Function size_to_bytes.
  - Function lane_mask(lane, size), returning {mask_word0[3:0], mask_word1[3:0]}.
- Sub-module mem_byte_lane: one 8-bit x DEPTH/4 array with write enable and registered synchronous read, instantiated four times.

Test Plan:
- Reset with DEPTH=256, CLEAR_ON_RESET=1 -> req_ready=0 for 64 cycles, then 1. A word load at 0xFC returns 0x00000000 at t+3.
- Word store 0xDEADBEEF at 0x10, then a byte load at 0x13 with req_signed=1 -> 0xFFFFFFDE at t+3. Same load with req_signed=0 -> 0x000000DE.
- Word store 0x11223344 at 0x0E (split) -> req_ready low one cycle. A word load at 0x0E -> 0x11223344 with resp_valid at t+4. A byte at 0x11 -> 0x11.
- Half store 0xA55A at 0xFF -> byte 0xFF=0x5A, byte 0x00=0xA5 (wrap). Half load at 0xFF, signed -> 0xFFFFA55A.
- Load resp with resp_ready held low 5 cycles -> resp_rdata stable and req_ready=0 throughout. Assert rst mid-RD1 -> resp_valid=0 next cycle and CLEAR restarts.
- With MEM_MISALIGN_TRAP_EN: word load at 0x02 -> resp_err=1, resp_rdata=0. req_size=11 load -> resp_err=1 in either build.
